// File: rtl/s3_timer8_pkg.sv
// Shared constants for the s3_timer8 period timer and its incrementer.
// Build option: define S3_TIMER8_PRESCALE_EN to enable the advance prescaler.
package s3_timer_pkg;

    localparam int TMR_W = 8;
    localparam int PSC_W = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/s3_timer8_inc8.sv
// s3_inc8: 8-bit ripple incrementer, x = a + 1 modulo 256.
// Build option: none (used by s3_timer8 as its only count source).
module s3_inc8
    import s3_timer_pkg::*;
(
    input  logic [TMR_W-1:0] a,
    output logic [TMR_W-1:0] x
);

    logic [TMR_W-1:0] w_c;

    assign w_c[0] = 1'b1;

    // Carry into bit i is set when every lower bit of a is 1.
    for (genvar i = 1; i < TMR_W; i++) begin : g_carry
        assign w_c[i] = w_c[i-1] & a[i-1];
    end

    assign x = a ^ w_c;

endmodule

// File: rtl/s3_timer8.sv
// s3_timer8: 8-bit programmable period timer with periodic/one-shot tick.
// Build option: define S3_TIMER8_PRESCALE_EN to gate advances by PRESCALE.
module s3_timer8
    import s3_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TMR_W-1:0] cfg_period,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    output logic [TMR_W-1:0] cnt,
    output logic             tick,
    output logic             busy
);

    localparam logic [PSC_W-1:0] LP_PSC = PRESCALE[PSC_W-1:0];

    logic [0:0]       r_state;
    logic [TMR_W-1:0] r_cnt;
    logic [TMR_W-1:0] r_period;
    logic             r_tick;
    logic [TMR_W-1:0] w_inc;
    logic             w_adv;
    logic             w_term;

    s3_inc8 u_inc (
        .a (r_cnt),
        .x (w_inc)
    );

`ifdef S3_TIMER8_PRESCALE_EN
    logic [PSC_W-1:0] r_psc;
    logic [PSC_W-1:0] w_psc_inc;

    assign w_adv     = (r_psc == LP_PSC);
    assign w_psc_inc = r_psc + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || stop || start || r_state != ST_RUN) begin
            r_psc <= '0;
        end else if (w_adv) begin
            r_psc <= '0;
        end else begin
            r_psc <= w_psc_inc;
        end
    end
`else
    logic w_unused_psc;

    assign w_unused_psc = |LP_PSC;
    assign w_adv        = 1'b1;
`endif

    assign w_term = (r_cnt == r_period);

    // Priority: rst, then stop, then start (restart), then normal RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_tick   <= 1'b0;
            r_period <= '0;
        end else if (stop) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
        end else if (start) begin
            r_state  <= ST_RUN;
            r_period <= cfg_period;
            r_cnt    <= '0;
            r_tick   <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (w_adv && w_term) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
                if (cfg_oneshot) begin
                    r_state <= ST_IDLE;
                end
            end else if (w_adv) begin
                r_cnt  <= w_inc;
                r_tick <= 1'b0;
            end else begin
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign cnt  = r_cnt;
    assign tick = r_tick;
    assign busy = (r_state == ST_RUN);

endmodule
